// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch sequencer states, PC increment and NOP encoding.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN        = 2'd1,
        REDIR_WAIT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
module load_use_detect
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_idex_memread,
    input  logic [REG_AW-1:0] i_idex_rt,
    input  logic [REG_AW-1:0] i_ifid_rs,
    input  logic [REG_AW-1:0] i_ifid_rt,
    output logic              o_load_use
);

    logic w_rt_nonzero;
    logic w_src_match;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign w_rt_nonzero = (i_idex_rt != REG_AW'(0));
    assign w_src_match  = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
    assign o_load_use   = i_idex_memread && w_rt_nonzero && w_src_match;

endmodule

// File: rtl/fetch_ctrl.sv
// Front-end sequencer: picks next PC and drives PC hold, IF/ID write/flush and ID/EX bubble.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       pc_i,
    input  logic              imem_stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_tgt_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rt_i,
    input  logic [REG_AW-1:0] ifid_rs_i,
    input  logic [REG_AW-1:0] ifid_rt_i,
    output logic [31:0]       pc_next_o,
    output logic              hazard_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fetch_state_e     r_state;
    fetch_state_e     w_next_state;
    logic [31:0]      r_pend;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_load_use;
    logic             w_pend_load;
    logic             w_stall_inc;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use (
        .i_idex_memread (idex_memread_i),
        .i_idex_rt      (idex_rt_i),
        .i_ifid_rs      (ifid_rs_i),
        .i_ifid_rt      (ifid_rt_i),
        .o_load_use     (w_load_use)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; dropping start_i always returns to IDLE
    always_comb begin
        w_next_state = r_state;
        if (!start_i) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: w_next_state = RUN;
                RUN: begin
                    if (!w_load_use && redirect_i && imem_stall_i) begin
                        w_next_state = REDIR_WAIT;
                    end
                end
                REDIR_WAIT: begin
                    if (!imem_stall_i) begin
                        w_next_state = RUN;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Output logic; defaults are the IDLE (hold everything, bubble EX) values
    always_comb begin
        pc_next_o     = pc_i;
        hazard_o      = 1'b1;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b1;
        if (start_i) begin
            case (r_state)
                RUN: begin
                    if (!w_load_use) begin
                        if (redirect_i && imem_stall_i) begin
                            ifid_write_o  = 1'b1;
                            ifid_flush_o  = 1'b1;
                            idex_bubble_o = 1'b0;
                        end else if (redirect_i) begin
                            pc_next_o     = redirect_tgt_i;
                            hazard_o      = 1'b0;
                            ifid_write_o  = 1'b1;
                            ifid_flush_o  = 1'b1;
                            idex_bubble_o = 1'b0;
                        end else if (!imem_stall_i) begin
                            pc_next_o     = pc_i + PC_INC;
                            hazard_o      = 1'b0;
                            ifid_write_o  = 1'b1;
                            idex_bubble_o = 1'b0;
                        end
                    end
                end
                REDIR_WAIT: begin
                    // The word arriving from the old PC is wrong-path, so it is flushed too
                    ifid_write_o  = 1'b1;
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b0;
                    if (!imem_stall_i) begin
                        pc_next_o = r_pend;
                        hazard_o  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_pend_load = (r_state == RUN) && (w_next_state == REDIR_WAIT);
    assign w_stall_inc = start_i && (r_state != IDLE) && hazard_o;

    // Redirect target held while imem finishes the in-flight fetch
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pend <= 32'd0;
        end else if (!start_i) begin
            r_pend <= 32'd0;
        end else if (w_pend_load) begin
            r_pend <= redirect_tgt_i;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ifid_flush_o && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule
